// File: rtl/text_frame_buffer_if.sv
// Bus bundle for the double-buffered text frame buffer: CPU cell port,
// page commands and VGA scanout port. clk/reset are passed separately.
interface text_frame_buffer_if #(
  parameter int AW     = 12,
  parameter int WORD_W = 32
);
  logic              cpu_we;
  logic [AW-1:0]     cpu_addr;
  logic [WORD_W-1:0] cpu_wdata;
  logic [WORD_W-1:0] cpu_rdata;
  logic              cmd_clear;
  logic [WORD_W-1:0] clear_value;
  logic              cmd_flip;
  logic              busy;
  logic              frame_start;
  logic [AW-1:0]     vga_addr;
  logic [WORD_W-1:0] vga_rdata;
  logic              front_page;

  // Requester side (CPU and VGA timing).
  modport master (
    output cpu_we, cpu_addr, cpu_wdata, cmd_clear, clear_value, cmd_flip,
           frame_start, vga_addr,
    input  cpu_rdata, busy, vga_rdata, front_page
  );

  // Frame buffer side.
  modport slave (
    input  cpu_we, cpu_addr, cpu_wdata, cmd_clear, clear_value, cmd_flip,
           frame_start, vga_addr,
    output cpu_rdata, busy, vga_rdata, front_page
  );
endinterface

// File: rtl/text_frame_buffer.sv
// Double-buffered character cell memory. The CPU reads/writes the back page,
// VGA scanout reads the front page. A clear fills the back page one cell per
// cycle; a flip swaps pages on the next frame_start pulse.
module text_frame_buffer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  text_frame_buffer_if.slave bus
);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = (CELLS > 1) ? $clog2(CELLS) : 1;
  // One extra bit so that CELLS itself is representable for range checks.
  localparam logic [AW:0]   CELLS_L = (AW + 1)'(CELLS);
  localparam logic [AW-1:0] LAST    = AW'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, FLIP_WAIT} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic              front_q, front_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WORD_W-1:0] vga_rdata_q, vga_rdata_d;

  // Page storage is never reset: contents survive reset and aborted clears.
  logic [WORD_W-1:0] page0 [CELLS];
  logic [WORD_W-1:0] page1 [CELLS];

  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              cpu_in_range;
  logic              vga_in_range;

  assign cpu_in_range = ({1'b0, bus.cpu_addr} < CELLS_L);
  assign vga_in_range = ({1'b0, bus.vga_addr} < CELLS_L);

  // Read muxes: CPU sees the back page, scanout sees the front page.
  always_comb begin
    cpu_rdata_d = '0;
    vga_rdata_d = '0;
    if (cpu_in_range) begin
      cpu_rdata_d = front_q ? page0[bus.cpu_addr] : page1[bus.cpu_addr];
    end
    if (vga_in_range) begin
      vga_rdata_d = front_q ? page1[bus.vga_addr] : page0[bus.vga_addr];
    end
  end

  // Control FSM next state, clear counter and back-page write port select.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    front_d   = front_q;
    mem_we    = 1'b0;
    mem_addr  = bus.cpu_addr;
    mem_wdata = bus.cpu_wdata;
    case (state_q)
      IDLE: begin
        // CPU writes only land while idle; commands here win over nothing.
        mem_we = bus.cpu_we & cpu_in_range;
        if (bus.cmd_clear) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (bus.cmd_flip) begin
          // A frame_start coinciding with the request is deliberately ignored.
          state_d = FLIP_WAIT;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = bus.clear_value;
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      FLIP_WAIT: begin
        if (bus.frame_start) begin
          front_d = ~front_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and read-data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      front_q     <= 1'b0;
      busy_q      <= 1'b0;
      cpu_rdata_q <= '0;
      vga_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      front_q     <= front_d;
      busy_q      <= busy_d;
      cpu_rdata_q <= cpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
    end
  end

  // Back-page write port (the page opposite the one being displayed).
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (front_q) begin
        page0[mem_addr] <= mem_wdata;
      end else begin
        page1[mem_addr] <= mem_wdata;
      end
    end
  end

  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.vga_rdata  = vga_rdata_q;
  assign bus.busy       = busy_q;
  assign bus.front_page = front_q;
endmodule

// File: tb/tb_text_frame_buffer.sv
// Bench for text_frame_buffer: a 4x2 instance (power-of-two cell count) and a
// 3x3 instance (addresses 9..15 out of range) driven by the same stimulus and
// compared every cycle with a behavioural page model.
module tb_text_frame_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_we;
  logic [3:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cmd_clear;
  logic [31:0] clear_value;
  logic        cmd_flip;
  logic        frame_start;
  logic [3:0]  vga_addr;

  always #5 clk = ~clk;

  text_frame_buffer_if #(.AW(3), .WORD_W(32)) ifa ();
  text_frame_buffer_if #(.AW(4), .WORD_W(32)) ifb ();

  assign ifa.cpu_we = cpu_we;          assign ifb.cpu_we = cpu_we;
  assign ifa.cpu_addr = cpu_addr[2:0]; assign ifb.cpu_addr = cpu_addr;
  assign ifa.cpu_wdata = cpu_wdata;    assign ifb.cpu_wdata = cpu_wdata;
  assign ifa.cmd_clear = cmd_clear;    assign ifb.cmd_clear = cmd_clear;
  assign ifa.clear_value = clear_value; assign ifb.clear_value = clear_value;
  assign ifa.cmd_flip = cmd_flip;      assign ifb.cmd_flip = cmd_flip;
  assign ifa.frame_start = frame_start; assign ifb.frame_start = frame_start;
  assign ifa.vga_addr = vga_addr[2:0]; assign ifb.vga_addr = vga_addr;

  text_frame_buffer #(.COLS(4), .ROWS(2), .WORD_W(32)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa));
  text_frame_buffer #(.COLS(3), .ROWS(3), .WORD_W(32)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb));

  // Behavioural model: per instance, two pages, displayed page, clear
  // cycles remaining and a pending-flip flag.
  int          cells [2] = '{8, 9};
  logic [31:0] mem   [2][2][16];
  bit          known [2][2][16];
  bit          mfront [2];
  int          clear_left [2];
  bit          pending [2];
  logic [31:0] exp_cpu [2];
  logic [31:0] exp_vga [2];
  bit          ek_cpu [2];
  bit          ek_vga [2];
  int          n_assert = 0;
  int          n_fail = 0;
  int          n_busy;

  function automatic int addr_of(int k, logic [3:0] a);
    return (k == 0) ? int'(a[2:0]) : int'(a);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mfront[k] = 1'b0; clear_left[k] = 0; pending[k] = 1'b0;
      exp_cpu[k] = '0; exp_vga[k] = '0; ek_cpu[k] = 1'b1; ek_vga[k] = 1'b1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int ca, va, bk, fr;
      ca = addr_of(k, cpu_addr);
      va = addr_of(k, vga_addr);
      fr = int'(mfront[k]);
      bk = 1 - fr;
      if (ca >= cells[k]) begin exp_cpu[k] = '0; ek_cpu[k] = 1'b1; end
      else begin exp_cpu[k] = mem[k][bk][ca]; ek_cpu[k] = known[k][bk][ca]; end
      if (va >= cells[k]) begin exp_vga[k] = '0; ek_vga[k] = 1'b1; end
      else begin exp_vga[k] = mem[k][fr][va]; ek_vga[k] = known[k][fr][va]; end
      if (clear_left[k] > 0) begin
        mem[k][bk][cells[k] - clear_left[k]] = clear_value;
        known[k][bk][cells[k] - clear_left[k]] = 1'b1;
        clear_left[k]--;
      end else if (pending[k]) begin
        if (frame_start) begin mfront[k] = ~mfront[k]; pending[k] = 1'b0; end
      end else begin
        if (cpu_we && ca < cells[k]) begin
          mem[k][bk][ca] = cpu_wdata; known[k][bk][ca] = 1'b1;
        end
        if (cmd_clear) clear_left[k] = cells[k];
        else if (cmd_flip) pending[k] = 1'b1;
      end
    end
  endtask

  task automatic check_all(string tag);
    for (int k = 0; k < 2; k++) begin
      logic [31:0] oc, ov;
      logic        ob, of;
      oc = (k == 0) ? ifa.cpu_rdata : ifb.cpu_rdata;
      ov = (k == 0) ? ifa.vga_rdata : ifb.vga_rdata;
      ob = (k == 0) ? ifa.busy : ifb.busy;
      of = (k == 0) ? ifa.front_page : ifb.front_page;
      check($sformatf("%s_%0d_busy", tag, k), 32'(ob),
            32'(clear_left[k] > 0 || pending[k]));
      check($sformatf("%s_%0d_front", tag, k), 32'(of), 32'(mfront[k]));
      if (ek_cpu[k]) check($sformatf("%s_%0d_cpu_rdata", tag, k), oc, exp_cpu[k]);
      if (ek_vga[k]) check($sformatf("%s_%0d_vga_rdata", tag, k), ov, exp_vga[k]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic idle_inputs();
    cpu_we = 1'b0; cmd_clear = 1'b0; cmd_flip = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    idle_inputs();
    cpu_addr = '0; vga_addr = '0; cpu_wdata = '0; clear_value = '0;
    model_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check_all("rst_async");
    tick();
    tick();
    reset = 1'b1;
    #2;
    check_all("rst_hold");
    tick();

    // Fill both pages: clear back (page1), flip, clear page0, flip back.
    clear_value = 32'h11; cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    repeat (10) tick();
    cmd_flip = 1'b1; tick(); cmd_flip = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    clear_value = 32'h22; cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    repeat (10) tick();
    cmd_flip = 1'b1; tick(); cmd_flip = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();
    check("init_front", 32'(ifa.front_page), 32'h0);

    // Back-page write and read; front still shows old contents.
    cpu_addr = 4'd5; vga_addr = 4'd5; cpu_wdata = 32'h41; cpu_we = 1'b1;
    tick(); cpu_we = 1'b0; tick();
    check("wr_cpu_rdata", ifa.cpu_rdata, 32'h41);
    check("wr_vga_old", ifa.vga_rdata, 32'h22);

    // Flip with frame_start three cycles after the request.
    cmd_flip = 1'b1; tick(); cmd_flip = 1'b0; tick(); tick();
    check("flip_wait_busy", 32'(ifa.busy), 32'h1);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("flip_front", 32'(ifa.front_page), 32'h1);
    check("flip_busy_low", 32'(ifa.busy), 32'h0);
    tick();
    check("flip_vga_new", ifa.vga_rdata, 32'h41);
    check("flip_cpu_old_front", ifa.cpu_rdata, 32'h22);

    // Clear with dropped CPU writes during busy.
    clear_value = 32'h20; cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    n_busy = 0; cpu_addr = 4'd2; cpu_wdata = 32'hBAD;
    for (int i = 0; i < 12; i++) begin
      if (ifa.busy) n_busy++;
      cpu_we = ifa.busy;
      tick();
    end
    cpu_we = 1'b0;
    check("clear_busy_cycles", 32'(n_busy), 32'd8);
    for (int a = 0; a < 8; a++) begin
      cpu_addr = 4'(a); tick();
      check($sformatf("clear_cell%0d", a), ifa.cpu_rdata, 32'h20);
    end

    // Flip request coinciding with frame_start waits for the next pulse.
    cmd_flip = 1'b1; frame_start = 1'b1; tick(); cmd_flip = 1'b0; frame_start = 1'b0;
    check("same_cycle_front", 32'(ifa.front_page), 32'h1);
    check("same_cycle_busy", 32'(ifa.busy), 32'h1);
    tick(); tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("next_frame_front", 32'(ifa.front_page), 32'h0);

    // Clear beats flip; a flip during busy is not queued.
    clear_value = 32'h33; cmd_clear = 1'b1; cmd_flip = 1'b1; tick();
    cmd_clear = 1'b0; cmd_flip = 1'b0; tick();
    cmd_flip = 1'b1; tick(); cmd_flip = 1'b0;
    repeat (10) tick();
    check("clr_flip_front", 32'(ifa.front_page), 32'h0);
    check("clr_flip_busy", 32'(ifa.busy), 32'h0);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    check("no_queued_flip", 32'(ifa.front_page), 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cpu_we      = 1'($urandom_range(0, 1));
      cpu_addr    = 4'($urandom_range(0, 15));
      cpu_wdata   = $urandom;
      cmd_clear   = ($urandom_range(0, 15) == 0);
      cmd_flip    = ($urandom_range(0, 7) == 0);
      frame_start = ($urandom_range(0, 5) == 0);
      clear_value = $urandom;
      vga_addr    = 4'($urandom_range(0, 15));
      tick();
    end
    idle_inputs();
    repeat (12) tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0; tick();

    // Reset in the middle of a clear.
    if (mfront[0]) begin
      cmd_flip = 1'b1; tick(); cmd_flip = 1'b0;
      frame_start = 1'b1; tick(); frame_start = 1'b0;
    end
    clear_value = 32'h55; cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    repeat (10) tick();
    clear_value = 32'h66; cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", 32'(ifa.busy), 32'h1);
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_abort");
    check("abort_busy", 32'(ifa.busy), 32'h0);
    check("abort_front", 32'(ifa.front_page), 32'h0);
    tick(); tick();
    reset = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      cpu_addr = 4'(a); tick();
      check($sformatf("abort_cell%0d", a), ifa.cpu_rdata,
            (a < 3) ? 32'h66 : 32'h55);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/text_frame_buffer.md
TEXT_FRAME_BUFFER -- requirements
Module: text_frame_buffer

Interface
REQ-001 SHALL have parameter COLS, default 80: character cells per row.
REQ-002 SHALL have parameter ROWS, default 30: character rows per page.
REQ-003 SHALL have parameter WORD_W, default 32: bits per cell (char code plus attributes).
REQ-004 SHALL derive CELLS = COLS*ROWS and AW = clog2(CELLS); all address ports are AW bits wide.
REQ-005 clk  input  1  sole clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 cpu_we  input  1  write strobe into the back page.
REQ-008 cpu_addr  input  AW  cell index for CPU read/write.
REQ-009 cpu_wdata  input  WORD_W  cell write data.
REQ-010 cpu_rdata  output  WORD_W  registered back-page read data.
REQ-011 cmd_clear  input  1  one-cycle request to fill the back page with clear_value.
REQ-012 clear_value  input  WORD_W  fill word, sampled every cycle of a clear.
REQ-013 cmd_flip  input  1  one-cycle request to swap pages at the next frame start.
REQ-014 busy  output  1  high while a clear or pending flip is in progress.
REQ-015 frame_start  input  1  one-cycle pulse from VGA timing at start of vertical blank.
REQ-016 vga_addr  input  AW  cell index for scanout.
REQ-017 vga_rdata  output  WORD_W  registered front-page read data.
REQ-018 front_page  output  1  index (0/1) of the page currently displayed.

Function
REQ-019 SHALL hold two pages of CELLS words each; the front page is front_page and the back page is ~front_page.
REQ-020 SHALL write cpu_wdata to back[cpu_addr] on a clk edge when cpu_we=1, busy=0 and cpu_addr<CELLS; otherwise the write SHALL be dropped.
REQ-021 SHALL present back[cpu_addr] on cpu_rdata one cycle after cpu_addr is applied; cpu_addr>=CELLS SHALL read 0.
REQ-022 SHALL present front[vga_addr] on vga_rdata one cycle after vga_addr is applied, every cycle including while busy; vga_addr>=CELLS SHALL read 0.
REQ-023 SHALL implement FSM states IDLE, CLEAR, FLIP_WAIT; busy=1 exactly when the state is not IDLE.
REQ-024 IDLE with cmd_clear=1 SHALL go to CLEAR with the cell counter at 0; cmd_clear SHALL win when cmd_clear and cmd_flip are high together, and the flip SHALL be dropped.
REQ-025 CLEAR SHALL write clear_value to back[counter] each cycle, incrementing the counter.
REQ-026 CLEAR SHALL return to IDLE on the cycle after the write to cell CELLS-1, so busy is high for exactly CELLS cycles.
REQ-027 IDLE with cmd_flip=1 (and cmd_clear=0) SHALL go to FLIP_WAIT; a frame_start in the same cycle as the request SHALL NOT complete the flip.
REQ-028 FLIP_WAIT with frame_start=1 SHALL toggle front_page on that edge and return to IDLE.
REQ-029 cmd_clear and cmd_flip received while busy=1 SHALL be ignored, not queued.
REQ-030 A CPU read during CLEAR SHALL return the current RAM contents (cleared or not); no forwarding is required.
REQ-031 After a flip, the CPU port SHALL address the former front page with no wait cycle.

Reset
REQ-032 reset low SHALL immediately force state IDLE, busy=0, front_page=0, cpu_rdata=0, vga_rdata=0 and clear counter=0.
REQ-033 Reset SHALL NOT initialise page contents; a clear aborted by reset SHALL leave the cells already written as written.
REQ-034 Outputs SHALL stay at reset values until the first clk edge after reset returns high.

Verification
REQ-035 Write 0x41 to cpu_addr 5, read cpu_addr 5 -> cpu_rdata=0x41 next cycle; vga_addr 5 still reads the old front value.
REQ-036 cmd_clear with clear_value=0x20 and COLS=4, ROWS=2 -> busy high 8 cycles; all 8 back cells = 0x20; CPU writes during busy are dropped.
REQ-037 cmd_flip, then frame_start 3 cycles later -> front_page 0->1 on that edge, busy low after; vga_addr 5 -> 0x41.
REQ-038 cmd_flip and frame_start in the same cycle -> no flip; the flip completes on the next frame_start pulse.
REQ-039 cmd_clear and cmd_flip together -> CLEAR runs; front_page unchanged after busy falls; cmd_flip issued during busy is ignored.
REQ-040 reset low at clear cycle 3 of 8 -> busy=0 immediately; cells 0-2 = clear_value; cells 3-7 unchanged; front_page=0.
